// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder, LSB first, one bit per clock.
// A single 1-bit slice (two half adders plus an OR for the carry) is reused for every bit.
// Handshake: start/busy/done. sum/cout are held stable between operations.
// Optional macro SERIAL_ADDER_OVF_EN adds a registered signed-overflow output, ovf.
module serial_adder_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t             state_q;
   logic [WIDTH-1:0]   a_sr_q;
   logic [WIDTH-1:0]   b_sr_q;
   logic [WIDTH-1:0]   part_q;
   logic [WIDTH-1:0]   part_d;
   logic               carry_q;
   logic               carry_d;
   logic [CNT_W-1:0]   cnt_q;
   logic               busy_q;
   logic               done_q;
   logic [WIDTH-1:0]   sum_q;
   logic               cout_q;
   logic               ha1_s;
   logic               ha1_c;
   logic               ha2_s;
   logic               ha2_c;
   logic               last_bit;
`ifdef SERIAL_ADDER_OVF_EN
   logic               ovf_q;
`endif

   // Shared 1-bit adder slice: two half adders, carries merged with an OR.
   assign ha1_s    = a_sr_q[0] ^ b_sr_q[0];
   assign ha1_c    = a_sr_q[0] & b_sr_q[0];
   assign ha2_s    = ha1_s ^ carry_q;
   assign ha2_c    = ha1_s & carry_q;
   assign carry_d  = ha1_c | ha2_c;
   assign part_d   = {ha2_s, part_q[WIDTH-1:1]};
   assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

   // Control FSM and serial datapath: load on accepted start, one bit per RUN cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         part_q  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  a_sr_q  <= a;
                  b_sr_q  <= b;
                  part_q  <= '0;
                  carry_q <= 1'b0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               a_sr_q  <= a_sr_q >> 1;
               b_sr_q  <= b_sr_q >> 1;
               part_q  <= part_d;
               carry_q <= carry_d;
               cnt_q   <= cnt_q + CNT_W'(1);
               if (last_bit) begin
                  // carry_q here is the carry into the MSB, carry_d the carry out of it
                  sum_q   <= part_d;
                  cout_q  <= carry_d;
`ifdef SERIAL_ADDER_OVF_EN
                  ovf_q   <= carry_q ^ carry_d;
`endif
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial N-bit adder controller. It time-shares a single 1-bit adder slice, built from two half-adder stages plus an OR for carry, across all operand bits: one bit per clock, LSB first. A start/busy/done handshake lets a host or a higher-level datapath issue additions. Result and carry-out are held stable between operations.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2)
CNT_W, $clog2(WIDTH)+1, bit-counter width (derived; not overridden)

Ports:
clk     input   1      rising-edge clock
rst     input   1      asynchronous, active-high reset
start   input   1      request; sampled only when busy=0
a       input   WIDTH  operand A, captured on accepted start
b       input   WIDTH  operand B, captured on accepted start
busy    output  1      high while an addition is in progress
done    output  1      one-cycle pulse: result valid
sum     output  WIDTH  registered result
cout    output  1      registered carry-out of MSB

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Internal shift registers, carry and counter are cleared.
- States:
  - IDLE: waiting for start.
  - RUN: one bit processed per cycle.
- IDLE -> RUN on the edge where start=1 (call it E0):
  - a and b loaded into shift registers; carry=0; count=0; busy=1 after E0.
- RUN, each edge:
  - Bit slice: s = a_sr[0]^b_sr[0]^c; c_next = (a_sr[0]&b_sr[0]) | (c&(a_sr[0]^b_sr[0])).
  - a_sr and b_sr shift right by one.
  - s is shifted into the MSB of the partial-result register.
  - carry <= c_next; count <= count+1.
- Completion on edge E_WIDTH (WIDTH edges after E0):
  - sum <= final partial result, including the bit computed on that edge.
  - cout <= final carry; state -> IDLE; busy -> 0; done -> 1.
- done is high for exactly one cycle and clears on the next edge.
- Latency: start accepted at E0 -> done/sum/cout valid after E_WIDTH. Throughput is one add per WIDTH cycles.
- sum/cout change only at completion. During RUN they keep the previous result.
- start while busy=1 is ignored. Operand inputs are not sampled during RUN.
- start=1 in the same cycle done=1 is accepted, since state is IDLE. This gives back-to-back operation with no idle cycle.
- Reset asserted mid-RUN: the operation is aborted immediately, all outputs go to reset values, and no done pulse is issued.
- Wrap-around: modulo 2^WIDTH; overflow is reported only via cout.
- No combinational path from inputs to outputs; all outputs are registered.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN
- Defined:
  - Extra output port ovf (output, 1): signed two's-complement overflow.
  - ovf = carry into MSB XOR carry out of MSB, registered at completion alongside sum/cout.
  - Reset value 0; held between operations.
- Undefined:
  - ovf port and its logic are absent.
  - All other behaviour is identical.

Test Plan:
1. Reset, then a=0x00, b=0x00, start 1 cycle -> busy high 8 cycles; done pulses once, 8 edges after the start edge; sum=0x00, cout=0.
2. a=0xFF, b=0x01, start -> sum=0x00, cout=1. With SERIAL_ADDER_OVF_EN: ovf=0.
3. a=0x5A, b=0x3C -> sum=0x96, cout=0. With SERIAL_ADDER_OVF_EN: ovf=1 (90+60 overflows signed 8-bit). sum stays at the prior 0x00 throughout RUN.
4. Start 0x10+0x20, re-pulse start with a=0xFF, b=0xFF at cycle 3 -> second request ignored; result sum=0x30, cout=0; exactly one done.
5. Start 0x0F+0x01, hold start=1 with new operands 0x80+0x80 through done -> first done gives sum=0x10, cout=0. Next op starts with no gap; second done 8 cycles later gives sum=0x00, cout=1.
6. Start 0xAA+0x55, assert rst at cycle 4 for 1 cycle -> busy=0, done=0, sum=0, cout=0 immediately (asynchronous); no done pulse follows. A subsequent 0x01+0x01 yields sum=0x02.
